// File: rtl/spi_nor_pkg.sv
// Shared opcodes, FSM state encoding and status-register layout for the SPI NOR responder.
package spi_nor_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PROG = 8'h02;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_SE   = 8'h20;

    localparam int SR_WIP = 0;
    localparam int SR_WEL = 1;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        STATUS,
        IGNORE
    } state_t;

    function automatic logic [7:0] sr_byte(input logic wel, input logic wip);
        logic [7:0] b;
        b         = 8'h00;
        b[SR_WEL] = wel;
        b[SR_WIP] = wip;
        return b;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Oversampling front end: synchronises s_clk/s_css/s_mosi into p_clk and flags s_clk edges
// and the chip-select release. s_mosi is delayed exactly like s_clk so it is stable at a rise.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_s_clk,
    input  logic       i_s_css,
    input  logic [7:0] i_s_mosi,
    output logic       o_clk_rise,
    output logic       o_clk_fall,
    output logic       o_css_n,
    output logic       o_css_rise,
    output logic [7:0] o_mosi_q
);

    logic [SYNC_STAGES-1:0] r_clk_sh;
    logic [SYNC_STAGES-1:0] r_css_sh;
    logic [7:0]             r_mosi_sh [SYNC_STAGES];
    logic                   r_clk_d;
    logic                   r_css_d;
    logic                   w_clk_s;
    logic                   w_css_s;

    // NOTE: sequential state uses non-blocking (<=) so every stage samples the previous
    // stage's old value; blocking here would collapse the chain into a single flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_sh <= '0;
            r_css_sh <= '1;
            r_clk_d  <= 1'b0;
            r_css_d  <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) r_mosi_sh[i] <= 8'h00;
        end else begin
            r_clk_sh[0]  <= i_s_clk;
            r_css_sh[0]  <= i_s_css;
            r_mosi_sh[0] <= i_s_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_clk_sh[i]  <= r_clk_sh[i-1];
                r_css_sh[i]  <= r_css_sh[i-1];
                r_mosi_sh[i] <= r_mosi_sh[i-1];
            end
            r_clk_d <= w_clk_s;
            r_css_d <= w_css_s;
        end
    end

    assign w_clk_s    = r_clk_sh[SYNC_STAGES-1];
    assign w_css_s    = r_css_sh[SYNC_STAGES-1];
    assign o_clk_rise = w_clk_s & ~r_clk_d;
    assign o_clk_fall = ~w_clk_s & r_clk_d;
    assign o_css_n    = w_css_s;
    assign o_css_rise = w_css_s & ~r_css_d;
    assign o_mosi_q   = r_mosi_sh[SYNC_STAGES-1];

endmodule

// File: rtl/spi_nor_responder.sv
// Byte-wide SPI NOR flash responder with NOR (AND-only) programming and a WIP busy timer.
// Optional SECTOR ERASE (opcode 8'h20) is built only when SPI_NOR_ERASE_EN is defined.
module spi_nor_responder
    import spi_nor_pkg::*;
#(
    parameter int MEM_AW      = 8,
    parameter int PROG_CYCLES = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       p_clk,
    input  logic       p_rst_n,
    input  logic       s_clk,
    input  logic       s_css,
    input  logic [7:0] s_mosi,
    output logic [7:0] s_miso
);

    localparam int DEPTH = 2 ** MEM_AW;
    localparam int CNT_W = $clog2(PROG_CYCLES + 1);

    logic              w_clk_rise;
    logic              w_clk_fall;
    logic              w_css_n;
    logic              w_css_rise;
    logic [7:0]        w_mosi_q;

    state_t            r_state;
    state_t            w_state_next;
    logic [7:0]        r_op;
    logic [23:0]       r_addr;
    logic [1:0]        r_addr_idx;
    logic              r_data_seen;
    logic              r_rd_primed;
    logic              r_wel;
    logic              r_wip;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_miso;
    logic [7:0]        r_mem [DEPTH];

    logic [MEM_AW-1:0] w_idx;
    logic [23:0]       w_rd_addr;
    logic              w_byte;
    logic              w_prog_we;
    logic              w_prog_done;
    logic              w_start_busy;
    logic              w_read_data;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk      (p_clk),
        .i_rst_n    (p_rst_n),
        .i_s_clk    (s_clk),
        .i_s_css    (s_css),
        .i_s_mosi   (s_mosi),
        .o_clk_rise (w_clk_rise),
        .o_clk_fall (w_clk_fall),
        .o_css_n    (w_css_n),
        .o_css_rise (w_css_rise),
        .o_mosi_q   (w_mosi_q)
    );

    // A byte only counts while the frame is open; a rise coinciding with the release is dropped.
    assign w_byte       = w_clk_rise & ~w_css_n;
    assign w_idx        = r_addr[MEM_AW-1:0];
    assign w_rd_addr    = r_rd_primed ? r_addr + 24'd1 : r_addr;
    assign w_read_data  = (r_state == DATA) && (r_op == OP_READ);
    assign w_prog_we    = (r_state == DATA) && (r_op == OP_PROG) && w_byte && r_wel;
    assign w_prog_done  = (r_state == DATA) && (r_op == OP_PROG) && w_css_rise && r_wel
                          && r_data_seen;

`ifdef SPI_NOR_ERASE_EN
    logic w_erase;
    assign w_erase      = (r_state == DATA) && (r_op == OP_SE) && w_css_rise && r_wel;
    assign w_start_busy = w_prog_done | w_erase;
`else
    assign w_start_busy = w_prog_done;
`endif

    always_ff @(posedge p_clk or negedge p_rst_n) begin
        if (!p_rst_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    // NOTE: every combinational output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        if (w_css_n) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: w_state_next = CMD;
                CMD: begin
                    if (w_byte) begin
                        if (r_wip) begin
                            w_state_next = (w_mosi_q == OP_RDSR) ? STATUS : IGNORE;
                        end else begin
                            case (w_mosi_q)
                                OP_READ, OP_PROG: w_state_next = ADDR;
`ifdef SPI_NOR_ERASE_EN
                                OP_SE:            w_state_next = ADDR;
`endif
                                OP_RDSR:          w_state_next = STATUS;
                                default:          w_state_next = IGNORE;
                            endcase
                        end
                    end
                end
                ADDR:    if (w_byte && r_addr_idx == 2'd2) w_state_next = DATA;
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge p_clk or negedge p_rst_n) begin
        if (!p_rst_n) begin
            r_op        <= 8'h00;
            r_addr      <= 24'h0;
            r_addr_idx  <= 2'd0;
            r_data_seen <= 1'b0;
            r_rd_primed <= 1'b0;
            r_wel       <= 1'b0;
            r_wip       <= 1'b0;
            r_cnt       <= '0;
            r_miso      <= 8'h00;
        end else begin
            // Busy timer: WEL drops together with WIP when the program/erase completes.
            if (w_start_busy) begin
                r_wip <= 1'b1;
                r_cnt <= CNT_W'(PROG_CYCLES);
            end else if (r_wip) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) begin
                    r_wip <= 1'b0;
                    r_wel <= 1'b0;
                end
            end

            if (r_state == CMD && w_byte) begin
                r_op        <= w_mosi_q;
                r_addr_idx  <= 2'd0;
                r_data_seen <= 1'b0;
                r_rd_primed <= 1'b0;
                if (!r_wip) begin
                    if (w_mosi_q == OP_WREN) r_wel <= 1'b1;
                    if (w_mosi_q == OP_WRDI) r_wel <= 1'b0;
                end
            end

            if (r_state == ADDR && w_byte) begin
                r_addr     <= {r_addr[15:0], w_mosi_q};
                r_addr_idx <= r_addr_idx + 2'd1;
            end

            // Programming wraps inside the 256-byte page; READ (below) wraps the whole array.
            if (w_prog_we) begin
                r_addr[7:0] <= r_addr[7:0] + 8'd1;
                r_data_seen <= 1'b1;
            end

            if (w_css_n) begin
                r_miso <= 8'h00;
            end else if (r_state == STATUS) begin
                if (w_clk_fall) r_miso <= sr_byte(r_wel, r_wip);
            end else if (w_read_data) begin
                if (w_clk_fall) begin
                    r_miso      <= r_mem[w_rd_addr[MEM_AW-1:0]];
                    r_addr      <= w_rd_addr;
                    r_rd_primed <= 1'b1;
                end
            end else begin
                r_miso <= 8'h00;
            end
        end
    end

    // NOTE: the array is reset to the erased value (8'hFF) on purpose: it models a blank
    // flash, so it lives in flops with an async reset rather than an inferred RAM.
    always_ff @(posedge p_clk or negedge p_rst_n) begin
        if (!p_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'hFF;
        end else begin
            if (w_prog_we) r_mem[w_idx] <= r_mem[w_idx] & w_mosi_q;
`ifdef SPI_NOR_ERASE_EN
            // 4 KiB sector compare; with MEM_AW <= 12 both sides are 0 and the whole array erases.
            if (w_erase) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if ((i >> 12) == (int'(w_idx) >> 12)) r_mem[i] <= 8'hFF;
                end
            end
`endif
        end
    end

    assign s_miso = r_miso;

endmodule

// File: tb/tb_spi_nor_responder.sv
// Self-checking bench for spi_nor_responder: directed scenarios plus randomised frames
// compared against a byte-array flash model.
`timescale 1ns/1ps
module tb_spi_nor_responder;

    localparam int MEM_AW      = 8;
    localparam int DEPTH       = 256;
    localparam int PROG_CYCLES = 64;
    localparam int HALF        = 8;

    logic       p_clk   = 1'b0;
    logic       p_rst_n = 1'b0;
    logic       s_clk   = 1'b0;
    logic       s_css   = 1'b1;
    logic [7:0] s_mosi  = 8'h00;
    logic [7:0] s_miso;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain byte array plus the two status flags.
    logic [7:0] m_mem [DEPTH];
    logic       m_wel;
    logic       m_wip;

    spi_nor_responder #(
        .MEM_AW      (MEM_AW),
        .PROG_CYCLES (PROG_CYCLES),
        .SYNC_STAGES (2)
    ) dut (
        .p_clk   (p_clk),
        .p_rst_n (p_rst_n),
        .s_clk   (s_clk),
        .s_css   (s_css),
        .s_mosi  (s_mosi),
        .s_miso  (s_miso)
    );

    always #5 p_clk = ~p_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'hFF;
        m_wel = 1'b0;
        m_wip = 1'b0;
    endtask

    function automatic logic [7:0] m_status();
        return {6'b0, m_wel, m_wip};
    endfunction

    task automatic cs_low();
        @(negedge p_clk);
        s_css = 1'b0;
        repeat (4) @(negedge p_clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge p_clk);
        s_css = 1'b1;
        repeat (6) @(negedge p_clk);
    endtask

    // rx is what the master sees on s_miso at the rising edge that carries tx.
    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        s_mosi = tx;
        repeat (HALF) @(negedge p_clk);
        rx    = s_miso;
        s_clk = 1'b1;
        repeat (HALF) @(negedge p_clk);
        s_clk = 1'b0;
    endtask

    task automatic send_addr(input logic [23:0] a);
        logic [7:0] rx;
        xfer(a[23:16], rx);
        xfer(a[15:8], rx);
        xfer(a[7:0], rx);
    endtask

    task automatic cmd1(input logic [7:0] op);
        logic [7:0] rx;
        cs_low();
        xfer(op, rx);
        cs_high();
        if (!m_wip && op == 8'h06) m_wel = 1'b1;
        if (!m_wip && op == 8'h04) m_wel = 1'b0;
    endtask

    task automatic rdsr(input string tag);
        logic [7:0] rx;
        logic [7:0] exp;
        exp = m_status();
        cs_low();
        xfer(8'h05, rx);
        check({tag, "_b1"}, rx, 8'h00);
        xfer(8'h00, rx);
        check(tag, rx, exp);
        cs_high();
    endtask

    task automatic prog(input logic [23:0] addr, input logic [7:0] d [$]);
        logic [7:0]  rx;
        logic [23:0] a;
        cs_low();
        xfer(8'h02, rx);
        send_addr(addr);
        foreach (d[k]) xfer(d[k], rx);
        cs_high();
        if (!m_wip && m_wel) begin
            a = addr;
            foreach (d[k]) begin
                m_mem[a[7:0]] = m_mem[a[7:0]] & d[k];
                a[7:0] = a[7:0] + 8'd1;
            end
            if (d.size() > 0) m_wip = 1'b1;
        end
    endtask

    task automatic read_chk(input string tag, input logic [23:0] addr, input int n);
        logic [7:0] rx;
        logic [7:0] exp;
        cs_low();
        xfer(8'h03, rx);
        send_addr(addr);
        for (int k = 0; k < n; k++) begin
            xfer(8'h00, rx);
            exp = m_wip ? 8'h00 : m_mem[(int'(addr) + k) % DEPTH];
            check(tag, rx, exp);
        end
        cs_high();
    endtask

    task automatic erase(input logic [23:0] addr);
        logic [7:0] rx;
        cs_low();
        xfer(8'h20, rx);
        send_addr(addr);
        cs_high();
`ifdef SPI_NOR_ERASE_EN
        if (!m_wip && m_wel) begin
            for (int i = 0; i < DEPTH; i++)
                if ((i / 4096) == ((int'(addr) % DEPTH) / 4096)) m_mem[i] = 8'hFF;
            m_wip = 1'b1;
        end
`endif
    endtask

    task automatic wait_done();
        repeat (PROG_CYCLES + 20) @(negedge p_clk);
        if (m_wip) begin
            m_wip = 1'b0;
            m_wel = 1'b0;
        end
    endtask

    initial begin
        #700us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  q [$];
        logic [7:0]  rx;
        logic [23:0] ra;
        int          op;
        int          len;

        model_reset();
        repeat (3) @(negedge p_clk);
        check("rst_miso", s_miso, 8'h00);
        p_rst_n = 1'b1;
        repeat (4) @(negedge p_clk);
        rdsr("rst_sr");

        // WREN / WRDI and the status byte
        cmd1(8'h06);
        rdsr("wren_sr");
        cmd1(8'h04);
        rdsr("wrdi_sr");

        // page program, busy window, read back
        cmd1(8'h06);
        q = {8'hA5, 8'h3C};
        prog(24'h000010, q);
        rdsr("prog_busy_sr");
        wait_done();
        rdsr("prog_done_sr");
        read_chk("prog_rd", 24'h000010, 2);
        read_chk("alias_rd", 24'hAB0010, 2);

        // NOR AND semantics
        cmd1(8'h06);
        q = {8'h0F};
        prog(24'h000020, q);
        wait_done();
        cmd1(8'h06);
        q = {8'hF0};
        prog(24'h000020, q);
        wait_done();
        read_chk("and_rd", 24'h000020, 1);

        // page wrap on program, array wrap on read
        cmd1(8'h06);
        q = {8'h11, 8'h22};
        prog(24'h0000FF, q);
        wait_done();
        read_chk("wrap_rd", 24'h0000FF, 2);

        // program aborted after two address bytes
        cmd1(8'h06);
        cs_low();
        xfer(8'h02, rx);
        xfer(8'h00, rx);
        xfer(8'h00, rx);
        cs_high();
        rdsr("abort_sr");
        read_chk("abort_rd", 24'h000000, 1);
        cmd1(8'h04);

        // reset in the middle of a READ
        cs_low();
        xfer(8'h03, rx);
        send_addr(24'h000010);
        xfer(8'h00, rx);
        check("mid_rd", rx, m_mem[8'h10]);
        repeat (HALF) @(negedge p_clk);
        p_rst_n = 1'b0;
        s_css   = 1'b1;
        #1;
        check("rst_mid_miso", s_miso, 8'h00);
        model_reset();
        repeat (3) @(negedge p_clk);
        p_rst_n = 1'b1;
        repeat (6) @(negedge p_clk);
        rdsr("rst_mid_sr");
        read_chk("rst_all_ff", 24'h000000, DEPTH);

        // sector erase (decoded only with SPI_NOR_ERASE_EN)
        cmd1(8'h06);
        q = {8'h00, 8'h12};
        prog(24'h000040, q);
        wait_done();
        cmd1(8'h06);
        erase(24'h000040);
        rdsr("erase_sr");
        wait_done();
        rdsr("erase_done_sr");
        read_chk("erase_rd", 24'h00003E, 4);
        cmd1(8'h04);

        // randomised frames against the model
        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 3);
            ra = 24'($urandom());
            case (op)
                0: begin
                    if ($urandom_range(0, 3) != 0) cmd1(8'h06);
                    len = $urandom_range(1, 4);
                    q.delete();
                    for (int k = 0; k < len; k++) q.push_back(8'($urandom_range(0, 255)));
                    prog(ra, q);
                    wait_done();
                end
                1: read_chk("rnd_rd", ra, $urandom_range(1, 6));
                2: cmd1($urandom_range(0, 1) != 0 ? 8'h06 : 8'h04);
                default: rdsr("rnd_sr");
            endcase
        end
        read_chk("final_rd", 24'h000000, DEPTH);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
